r2r_sar_adc: RTL
================

# r2r_sar_adc

Conversion controller for the R2R-ladder ADC path. It drives the 8-bit R2R DAC code, waits a programmable settle time per step, and samples the external comparator. It runs either a successive-approximation search or, optionally, a linear ramp search. The result is handed to the downstream scaling and 7-segment display logic with a one-cycle valid strobe. It sits between the board pins `comp_r2r`/`R2R_out` and the display path in `ADC_Project_Top_Level`.

## Interface
- `DATA_WIDTH`, 8, DAC/result width
- `SETTLE_CYCLES`, 6250, clocks per SAR bit trial (62.5 µs at 100 MHz)
- `RAMP_SETTLE_CYCLES`, 625, clocks per ramp step (ramp build only)
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  level; while high, conversions run back-to-back
- `algorithm_sel`  in  1  0 = SAR, 1 = ramp; sampled only at conversion start
- `comp_in`  in  1  asynchronous comparator output; 1 = Vin ≥ DAC voltage
- `r2r_out`  out  DATA_WIDTH  DAC code driven to the ladder
- `sample_out`  out  DATA_WIDTH  last completed conversion result
- `sample_valid`  out  1  one-cycle strobe; `sample_out` is updated on the same cycle
- `busy`  out  1  high while in SETTLE

## Operation
- `comp_in` passes through a 2-flop synchronizer to give `comp_s`. All decisions use `comp_s`.
- States: IDLE, SETTLE, DONE. A settle counter counts 0..N-1, where N = `SETTLE_CYCLES` for SAR and `RAMP_SETTLE_CYCLES` for ramp.
- IDLE with `enable`=1:
  - Latch `algorithm_sel` into `mode`, clear the counter, go to SETTLE.
  - SAR: `r2r_out` ← 0x80, bit index ← 7.
  - Ramp: `r2r_out` ← 0x00.
- SETTLE, SAR, on terminal count N-1:
  - If `comp_s`=0, clear the current bit. Otherwise keep it.
  - If index = 0, go to DONE.
  - Otherwise set the next lower bit, decrement the index, restart the counter.
- SETTLE, ramp, on terminal count:
  - If `comp_s`=0: result = `r2r_out`-1, floored at 0 when `r2r_out`=0. Go to DONE.
  - Else if `r2r_out`=0xFF: result = 0xFF. Go to DONE.
  - Else increment `r2r_out` and restart the counter.
- DONE, one cycle:
  - `sample_out` ← result and `sample_valid`=1.
  - `r2r_out` holds the result code. Go to IDLE.
- Back-to-back operation: with `enable` held high, IDLE is occupied one cycle and the next conversion starts.
- Deasserting `enable` mid-conversion does not abort; the current conversion completes.
- `algorithm_sel` changes mid-conversion are ignored until the next start.
- `comp_in` transitions within a settle window only matter if present in `comp_s` at terminal count.

## Timing
- Reset (`reset`=0 at a clock edge) sets:
  - state = IDLE
  - `r2r_out` = 0, `sample_out` = 0
  - `sample_valid` = 0, `busy` = 0
  - counter = 0, synchronizer = 0
- Reset mid-conversion takes effect the same edge, and no `sample_valid` is issued.
- Conversion start is defined as the edge on which IDLE sees `enable`=1. That edge loads the trial code.
- SAR latency: `sample_valid` is high in the cycle 8·`SETTLE_CYCLES`+1 clocks after the start edge. Each trial code is driven for exactly `SETTLE_CYCLES` clocks.
- Back-to-back SAR period is 8·`SETTLE_CYCLES`+2 clocks.
- Ramp latency for stop code k (comparator low at step k) is (k+1)·`RAMP_SETTLE_CYCLES`+1 clocks.
- The comparator is sampled 2 clocks after its pin edge. Stimulus must be stable from settle start+2 through terminal count.
- `busy` is 0 in IDLE and DONE.

## Configuration
- `R2R_RAMP_EN` defined:
  - Ramp search and `RAMP_SETTLE_CYCLES` are compiled in.
  - `algorithm_sel`=1 selects ramp.
- `R2R_RAMP_EN` undefined:
  - Ramp logic is absent and `algorithm_sel` is ignored.
  - Every conversion is SAR, and the ramp parameter is unused.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with `enable`=1 → all outputs 0, no `sample_valid`. After release, the first `r2r_out`=0x80 appears one cycle after the start edge.
- **SAR default timing:** `SETTLE_CYCLES`=6250. Drive `comp_in` per 62.5 µs bit window, MSB first, as 1,1,0,1,1,0,1,0.
  - `r2r_out` steps 0x80, 0xC0, 0xE0, 0xD0, 0xD8, 0xDC, 0xDA, 0xDB.
  - `sample_out`=0xDA, with `sample_valid` at 50 001 cycles.
- **SAR extremes:** `SETTLE_CYCLES`=4.
  - `comp_in` stuck 1 → 0xFF. Stuck 0 → 0x00.
  - Back-to-back `sample_valid` strobes are 34 cycles apart.
- **Ramp (`R2R_RAMP_EN`):** `RAMP_SETTLE_CYCLES`=4, `algorithm_sel`=1, `comp_in` falls when `r2r_out` reaches 0x25 → `sample_out`=0x24, `sample_valid` at 153 cycles.
  - `comp_in` always 1 → 0xFF.
  - `comp_in` always 0 → 0x00.
- **Mid-conversion events:**
  - Toggling `algorithm_sel` and dropping `enable` mid-SAR → conversion finishes as SAR, then stays IDLE.
  - Asserting `reset`=0 mid-SAR → outputs 0 next edge, no strobe.
- **Without `R2R_RAMP_EN`:** `algorithm_sel`=1 with the bit pattern 1,1,0,1,1,0,1,0 → SAR result 0xDA.

Source files
------------

// File: rtl/r2r_sar_adc.sv
// R2R-ladder ADC conversion controller: SAR search, plus an optional linear
// ramp search compiled in when the R2R_RAMP_EN macro is defined.
module r2r_sar_adc #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES      = 6250,
  parameter int unsigned RAMP_SETTLE_CYCLES = 625
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  algorithm_sel,
  input  logic                  comp_in,
  output logic [DATA_WIDTH-1:0] r2r_out,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int unsigned MAX_SETTLE = (SETTLE_CYCLES > RAMP_SETTLE_CYCLES) ?
                                       SETTLE_CYCLES : RAMP_SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_SETTLE > 1) ? $clog2(MAX_SETTLE) : 1;
  localparam int unsigned IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0]      SAR_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_CODE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`ifdef R2R_RAMP_EN
  localparam logic [CNT_W-1:0]      RAMP_LAST = CNT_W'(RAMP_SETTLE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CODE_MAX  = {DATA_WIDTH{1'b1}};
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [1:0]              sync_q;
  logic                    comp_s;
  logic                    term_d;
  logic [DATA_WIDTH-1:0]   bit_mask_d;
  logic [DATA_WIDTH-1:0]   sar_kept_d;
`ifdef R2R_RAMP_EN
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   ramp_res_d;
`else
  logic                    alg_sel_unused;
  assign alg_sel_unused = algorithm_sel;
`endif

  assign comp_s = sync_q[1];

  // Trial decision: current bit kept or cleared, ramp stop code floored at zero
  always_comb begin
    term_d     = (cnt_q == SAR_LAST);
    bit_mask_d = DATA_WIDTH'(1) << idx_q;
    sar_kept_d = comp_s ? r2r_out : (r2r_out & ~bit_mask_d);
`ifdef R2R_RAMP_EN
    ramp_res_d = (r2r_out == '0) ? '0 : (r2r_out - DATA_WIDTH'(1));
    if (mode_q) begin
      term_d = (cnt_q == RAMP_LAST);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sync_q       <= '0;
      r2r_out      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef R2R_RAMP_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], comp_in};
      sample_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            cnt_q   <= '0;
            idx_q   <= IDX_W'(DATA_WIDTH - 1);
            busy    <= 1'b1;
            state_q <= SETTLE;
`ifdef R2R_RAMP_EN
            mode_q  <= algorithm_sel;
            r2r_out <= algorithm_sel ? '0 : MSB_CODE;
`else
            r2r_out <= MSB_CODE;
`endif
          end
        end

        SETTLE: begin
          if (!term_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
`ifdef R2R_RAMP_EN
            // Ramp: stop one code below the first step the comparator rejects
            if (mode_q) begin
              if (!comp_s) begin
                r2r_out <= ramp_res_d;
                busy    <= 1'b0;
                state_q <= DONE;
              end else if (r2r_out == CODE_MAX) begin
                busy    <= 1'b0;
                state_q <= DONE;
              end else begin
                r2r_out <= r2r_out + DATA_WIDTH'(1);
              end
            end else
`endif
            begin
              if (idx_q == '0) begin
                r2r_out <= sar_kept_d;
                busy    <= 1'b0;
                state_q <= DONE;
              end else begin
                r2r_out <= sar_kept_d | (bit_mask_d >> 1);
                idx_q   <= idx_q - IDX_W'(1);
              end
            end
          end
        end

        DONE: begin
          sample_out   <= r2r_out;
          sample_valid <= 1'b1;
          state_q      <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
